// File: rtl/execute_alu_cmtq.sv
// Commit-delay queue between the ALU output register and the ROB writeback
// port. Each accepted result waits for its commit delay to run out. The
// lowest-index ready entry then retires, at most one per cycle.

// One queue slot: payload plus a saturating countdown.
module execute_alu_cmtq_entry (
  input  logic        clk,
  input  logic        resetn,
  input  logic        alloc,
  input  logic        free,
  input  logic        flush,
  input  logic [3:0]  in_dst_rob,
  input  logic [7:0]  in_fid,
  input  logic [31:0] in_result,
  input  logic [3:0]  in_cmtdelay,
  output logic        occ,
  output logic [3:0]  dst_rob,
  output logic [7:0]  fid,
  output logic [31:0] result,
  output logic [3:0]  cnt
);
  // Occupancy: flush beats allocation, and allocation beats a same-edge free
  // (the full-queue slot reuse case).
  always_ff @(posedge clk) begin
    if (!resetn)    occ <= 1'b0;
    else if (flush) occ <= 1'b0;
    else if (alloc) occ <= 1'b1;
    else if (free)  occ <= 1'b0;
  end

  // Payload load on allocation, otherwise count down toward zero and hold there.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      dst_rob <= '0;
      fid     <= '0;
      result  <= '0;
      cnt     <= '0;
    end else if (alloc) begin
      dst_rob <= in_dst_rob;
      fid     <= in_fid;
      result  <= in_result;
      cnt     <= in_cmtdelay;
    end else if (occ && cnt != 4'd0) begin
      cnt <= cnt - 4'd1;
    end
  end
endmodule

module execute_alu_cmtq #(
  parameter  int DEPTH = 16,
  localparam int IDXW  = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          resetn,
  input  logic          i_valid,
  input  logic [3:0]    i_dst_rob,
  input  logic [7:0]    i_fid,
  input  logic [31:0]   i_result,
  input  logic [3:0]    i_cmtdelay,
  input  logic          i_flush,
  output logic          o_wb_valid,
  output logic [3:0]    o_wb_dst_rob,
  output logic [7:0]    o_wb_fid,
  output logic [31:0]   o_wb_result,
  output logic [IDXW:0] o_count,
  output logic          o_overflow
);
  localparam int CW = IDXW + 1;

  logic [DEPTH-1:0]        e_occ, rdy, alloc, free;
  logic [DEPTH-1:0][3:0]   e_dst, e_cnt;
  logic [DEPTH-1:0][7:0]   e_fid;
  logic [DEPTH-1:0][31:0]  e_res;
  logic                    sel_vld, has_free, cap_ok, drop;
  logic [IDXW-1:0]         sel_idx, free_idx, alloc_idx;
  logic [CW-1:0]           count_q;
  logic                    ovf_q;

  genvar g;
  generate
    for (g = 0; g < DEPTH; g++) begin : g_ent
      execute_alu_cmtq_entry u_ent (
        .clk        (clk),
        .resetn     (resetn),
        .alloc      (alloc[g]),
        .free       (free[g]),
        .flush      (i_flush),
        .in_dst_rob (i_dst_rob),
        .in_fid     (i_fid),
        .in_result  (i_result),
        .in_cmtdelay(i_cmtdelay),
        .occ        (e_occ[g]),
        .dst_rob    (e_dst[g]),
        .fid        (e_fid[g]),
        .result     (e_res[g]),
        .cnt        (e_cnt[g])
      );
      assign rdy[g] = e_occ[g] && (e_cnt[g] == 4'd0);
    end
  endgenerate

  // Lowest-index ready entry for writeback, lowest-index free slot for capture.
  always_comb begin
    sel_vld  = 1'b0;
    sel_idx  = '0;
    has_free = 1'b0;
    free_idx = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (rdy[i]) begin
        sel_vld = 1'b1;
        sel_idx = IDXW'(i);
      end
      if (!e_occ[i]) begin
        has_free = 1'b1;
        free_idx = IDXW'(i);
      end
    end
  end

  // Only a full queue may reuse the slot being retired this edge.
  always_comb begin
    cap_ok    = i_valid && !i_flush && (has_free || sel_vld);
    drop      = i_valid && !i_flush && !has_free && !sel_vld;
    alloc_idx = has_free ? free_idx : sel_idx;
    alloc     = cap_ok  ? (DEPTH'(1) << alloc_idx) : '0;
    free      = sel_vld ? (DEPTH'(1) << sel_idx)   : '0;
  end

  // Writeback beat straight from queue state, zeroed when idle.
  always_comb begin
    o_wb_valid   = sel_vld;
    o_wb_dst_rob = sel_vld ? e_dst[sel_idx] : '0;
    o_wb_fid     = sel_vld ? e_fid[sel_idx] : '0;
    o_wb_result  = sel_vld ? e_res[sel_idx] : '0;
  end

  // Occupancy counter tracks capture/writeback; flush empties it.
  always_ff @(posedge clk) begin
    if (!resetn)      count_q <= '0;
    else if (i_flush) count_q <= '0;
    else              count_q <= count_q + CW'(cap_ok) - CW'(sel_vld);
  end

  // Sticky drop flag, cleared only by reset.
  always_ff @(posedge clk) begin
    if (!resetn)   ovf_q <= 1'b0;
    else if (drop) ovf_q <= 1'b1;
  end

  assign o_count    = count_q;
  assign o_overflow = ovf_q;
endmodule

// File: tb/tb_execute_alu_cmtq.sv
// Bench for execute_alu_cmtq (DEPTH=4). Stimulus pushes the hand-computed
// writeback beat and its cycle into a queue; a negedge monitor pops and
// compares every beat the DUT presents.
module tb_execute_alu_cmtq;
  logic        clk = 1'b0;
  logic        resetn;
  logic        i_valid, i_flush;
  logic [3:0]  i_dst_rob, i_cmtdelay;
  logic [7:0]  i_fid;
  logic [31:0] i_result;
  logic        o_wb_valid, o_overflow;
  logic [3:0]  o_wb_dst_rob;
  logic [7:0]  o_wb_fid;
  logic [31:0] o_wb_result;
  logic [2:0]  o_count;

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;

  typedef struct { logic [43:0] beat; int at; } exp_t;
  exp_t sb[$];

  execute_alu_cmtq #(.DEPTH(4)) dut (
    .clk(clk), .resetn(resetn), .i_valid(i_valid), .i_dst_rob(i_dst_rob),
    .i_fid(i_fid), .i_result(i_result), .i_cmtdelay(i_cmtdelay),
    .i_flush(i_flush), .o_wb_valid(o_wb_valid), .o_wb_dst_rob(o_wb_dst_rob),
    .o_wb_fid(o_wb_fid), .o_wb_result(o_wb_result), .o_count(o_count),
    .o_overflow(o_overflow)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every presented beat must match the head of the scoreboard.
  always @(negedge clk) begin
    if (o_wb_valid === 1'b1) begin
      if (sb.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL unexpected_wb: got %0h expected none (cycle %0d)",
                 {o_wb_dst_rob, o_wb_fid, o_wb_result}, cyc);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("wb_beat", {20'd0, o_wb_dst_rob, o_wb_fid, o_wb_result}, {20'd0, e.beat});
        check("wb_cycle", 64'(cyc), 64'(e.at));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [3:0] dst, input logic [7:0] fid,
                       input logic [31:0] res, input logic [3:0] d);
    i_valid = 1'b1; i_dst_rob = dst; i_fid = fid; i_result = res; i_cmtdelay = d;
    tick();
    i_valid = 1'b0;
  endtask

  task automatic expect_wb(input logic [3:0] dst, input logic [7:0] fid,
                           input logic [31:0] res, input int at);
    exp_t e;
    e.beat = {dst, fid, res};
    e.at   = at;
    sb.push_back(e);
  endtask

  task automatic drained(input string name);
    check(name, 64'(sb.size()), 64'd0);
    sb.delete();
  endtask

  int c0;

  initial begin
    resetn = 1'b0; i_valid = 1'b0; i_flush = 1'b0;
    i_dst_rob = '0; i_fid = '0; i_result = '0; i_cmtdelay = '0;
    #1;

    // Reset and minimum latency
    tick(); tick();
    check("rst_wb_valid", 64'(o_wb_valid), 64'd0);
    check("rst_wb_data", {20'd0, o_wb_dst_rob, o_wb_fid, o_wb_result}, 64'd0);
    check("rst_count", 64'(o_count), 64'd0);
    check("rst_ovf", 64'(o_overflow), 64'd0);
    resetn = 1'b1;
    c0 = cyc;
    expect_wb(4'd5, 8'h3C, 32'hDEADBEEF, c0 + 1);
    issue(4'd5, 8'h3C, 32'hDEADBEEF, 4'd0);
    check("byp_count_1", 64'(o_count), 64'd1);
    tick();
    check("byp_count_0", 64'(o_count), 64'd0);
    tick();
    drained("byp_drained");

    // Delay ordering: B overtakes A
    c0 = cyc;
    expect_wb(4'd2, 8'h0B, 32'h0000_B0B0, c0 + 2);
    expect_wb(4'd1, 8'h0A, 32'h0000_A0A0, c0 + 4);
    issue(4'd1, 8'h0A, 32'h0000_A0A0, 4'd3);
    issue(4'd2, 8'h0B, 32'h0000_B0B0, 4'd0);
    repeat (6) tick();
    drained("order_drained");
    check("order_count", 64'(o_count), 64'd0);

    // Contention: all ready together, retire by slot index
    c0 = cyc;
    expect_wb(4'd3, 8'h11, 32'h1111_1111, c0 + 3);
    expect_wb(4'd4, 8'h22, 32'h2222_2222, c0 + 4);
    expect_wb(4'd6, 8'h33, 32'h3333_3333, c0 + 5);
    issue(4'd3, 8'h11, 32'h1111_1111, 4'd2);
    issue(4'd4, 8'h22, 32'h2222_2222, 4'd1);
    issue(4'd6, 8'h33, 32'h3333_3333, 4'd0);
    repeat (6) tick();
    drained("cont_drained");

    // Full and overflow; full-queue slot reuse
    c0 = cyc;
    expect_wb(4'd8,  8'h40, 32'h4000_0000, c0 + 16);
    expect_wb(4'd13, 8'h45, 32'h4500_0000, c0 + 17);
    expect_wb(4'd9,  8'h41, 32'h4100_0000, c0 + 18);
    expect_wb(4'd10, 8'h42, 32'h4200_0000, c0 + 19);
    expect_wb(4'd11, 8'h43, 32'h4300_0000, c0 + 20);
    issue(4'd8,  8'h40, 32'h4000_0000, 4'd15);
    issue(4'd9,  8'h41, 32'h4100_0000, 4'd15);
    issue(4'd10, 8'h42, 32'h4200_0000, 4'd15);
    issue(4'd11, 8'h43, 32'h4300_0000, 4'd15);
    check("full_ovf_before", 64'(o_overflow), 64'd0);
    issue(4'd12, 8'h44, 32'h4400_0000, 4'd0);
    check("full_ovf", 64'(o_overflow), 64'd1);
    check("full_count", 64'(o_count), 64'd4);
    while (cyc < c0 + 16) tick();
    issue(4'd13, 8'h45, 32'h4500_0000, 4'd0);
    check("reuse_count", 64'(o_count), 64'd4);
    repeat (6) tick();
    drained("full_drained");
    check("full_count_0", 64'(o_count), 64'd0);

    // Flush with a concurrent input
    issue(4'd1, 8'h51, 32'h5100_0000, 4'd10);
    issue(4'd2, 8'h52, 32'h5200_0000, 4'd10);
    issue(4'd3, 8'h53, 32'h5300_0000, 4'd10);
    check("pre_flush_count", 64'(o_count), 64'd3);
    i_flush = 1'b1;
    issue(4'd4, 8'h54, 32'h5400_0000, 4'd0);
    i_flush = 1'b0;
    check("flush_count", 64'(o_count), 64'd0);
    check("flush_wb_valid", 64'(o_wb_valid), 64'd0);
    check("flush_ovf", 64'(o_overflow), 64'd1);
    repeat (15) tick();
    drained("flush_drained");

    // Reset mid-operation
    c0 = cyc;
    expect_wb(4'd7, 8'h60, 32'h6000_0000, c0 + 1);
    issue(4'd7, 8'h60, 32'h6000_0000, 4'd0);
    issue(4'd7, 8'h61, 32'h6100_0000, 4'd5);
    issue(4'd7, 8'h62, 32'h6200_0000, 4'd9);
    issue(4'd7, 8'h63, 32'h6300_0000, 4'd12);
    issue(4'd7, 8'h64, 32'h6400_0000, 4'd14);
    check("mid_count", 64'(o_count), 64'd4);
    resetn = 1'b0;
    tick();
    resetn = 1'b1;
    check("mid_rst_count", 64'(o_count), 64'd0);
    check("mid_rst_ovf", 64'(o_overflow), 64'd0);
    check("mid_rst_wb_valid", 64'(o_wb_valid), 64'd0);
    repeat (20) tick();
    drained("mid_drained");
    check("end_count", 64'(o_count), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
